multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 121 ++++++++++++
 tb/tb_multiplier.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Sequential shift-and-add 32x32 multiplier with signed/unsigned operand
// control and selectable product half. One iteration per clock in RUN.
// Optional feature macro: MULT_EARLY_EXIT_EN -- when defined, RUN ends as
// soon as the remaining multiplier magnitude becomes zero; results are the
// same either way, only the latency changes.
module multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mult_half,
    input  logic        mult_signed_a,
    input  logic        mult_signed_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    logic [63:0] mcand_reg;     // multiplicand magnitude, shifted left each iteration
    logic [31:0] mplier_reg;    // multiplier magnitude, shifted right each iteration
    logic [63:0] acc_reg;       // running sum of partial products
    logic [4:0]  count_reg;     // iteration index 0..31
    logic        neg_reg;       // product sign
    logic        half_reg;      // latched half select
    logic [31:0] result_reg;

    logic [31:0] a_mag, b_mag;
    logic        sign_next;
    logic        accept;
    logic [63:0] acc_sum;
    logic [31:0] mplier_shift;
    logic [63:0] product;
    logic        last_iter;

    // Operand magnitudes and sign; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        a_mag     = (mult_signed_a && a[31]) ? (~a + 32'd1) : a;
        b_mag     = (mult_signed_b && b[31]) ? (~b + 32'd1) : b;
        sign_next = (mult_signed_a & a[31]) ^ (mult_signed_b & b[31]);
        accept    = (state_reg == IDLE) && start && !abort;
    end

    // One shift-and-add step plus the signed final product for the last step.
    always_comb begin
        acc_sum      = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);
        mplier_shift = mplier_reg >> 1;
        product      = neg_reg ? (~acc_sum + 64'd1) : acc_sum;
`ifdef MULT_EARLY_EXIT_EN
        last_iter    = (count_reg == 5'd31) || (mplier_shift == 32'd0);
`else
        last_iter    = (count_reg == 5'd31);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides every transition, start only counts in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Datapath: load operands on accept, iterate in RUN, capture result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= 64'd0;
            mplier_reg <= 32'd0;
            acc_reg    <= 64'd0;
            count_reg  <= 5'd0;
            neg_reg    <= 1'b0;
            half_reg   <= 1'b0;
            result_reg <= 32'd0;
        end else if (accept) begin
            mcand_reg  <= {32'd0, a_mag};
            mplier_reg <= b_mag;
            acc_reg    <= 64'd0;
            count_reg  <= 5'd0;
            neg_reg    <= sign_next;
            half_reg   <= mult_half;
        end else if (state_reg == RUN && !abort) begin
            acc_reg    <= acc_sum;
            mplier_reg <= mplier_shift;
            mcand_reg  <= mcand_reg << 1;
            count_reg  <= count_reg + 5'd1;
            if (last_iter) begin
                result_reg <= half_reg ? product[63:32] : product[31:0];
            end
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vectors, control sequencing
// (abort, ignored start, reset mid-run) and randomized operands compared
// against an arithmetic product model.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] a, b;
    logic        mult_half, mult_signed_a, mult_signed_b;
    logic        busy, done;
    logic [31:0] result;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;

    multiplier dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .a             (a),
        .b             (b),
        .mult_half     (mult_half),
        .mult_signed_a (mult_signed_a),
        .mult_signed_b (mult_signed_b),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full-precision signed/unsigned product, then pick the requested half.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic h, input logic sx, input logic sy);
        logic signed [63:0] xe, ye, p;
        xe = sx ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sy ? {{32{y[31]}}, y} : {32'd0, y};
        p  = xe * ye;
        return h ? p[63:32] : p[31:0];
    endfunction

    // Cycles from the accepting edge until done is visible.
    function automatic int ref_latency(input logic [31:0] y, input logic sy);
        logic [31:0] mag;
        int          k;
        mag = (sy && y[31]) ? (32'd0 - y) : y;
        k   = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
`ifdef MULT_EARLY_EXIT_EN
        return 1 + k;
`else
        return 33;
`endif
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic th,
                          input logic tsa, input logic tsb, input logic [31:0] exp,
                          input string tag);
        int cyc;
        int lat;
        lat = ref_latency(tb_v, tsb);
        @(negedge clk);
        a = ta; b = tb_v; mult_half = th; mult_signed_a = tsa; mult_signed_b = tsb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // operands must be latched; scramble the inputs after acceptance
        a = $urandom; b = $urandom;
        mult_half = 1'($urandom); mult_signed_a = 1'($urandom); mult_signed_b = 1'($urandom);
        cyc = 1;
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        chk({tag, " result_held"}, 64'(result), 64'(last_result));
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, 64'(result), 64'(exp));
        $display("op %s a=%h b=%h half=%0d sa=%0d sb=%0d -> result=%h lat=%0d",
                 tag, ta, tb_v, th, tsa, tsb, result, cyc);
        last_result = exp;
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
        chk({tag, " busy_clear"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rh, rsa, rsb;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        a = 32'd0; b = 32'd0; mult_half = 1'b0; mult_signed_a = 1'b0; mult_signed_b = 1'b0;
        last_result = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0000002A, "7x6");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h00000001, "m1xm1_lo");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000, "m1xm1_hi");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, "umax_hi");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, "su_hi");
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000, "min_sq_hi");
        run_op(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0000001B, "9x3");
        run_op(32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, "bzero");

        // start during RUN ignored, abort flushes with no done and result unchanged
        @(negedge clk);
        a = 32'd5; b = 32'd5; mult_half = 1'b0; mult_signed_a = 1'b0; mult_signed_b = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            start = (e == 5);
            abort = (e == 10);
            @(posedge clk); #1;
            if (e < 10) chk($sformatf("abort_seq busy e%0d", e), 64'(busy), 64'd1);
            else        chk($sformatf("abort_seq idle e%0d", e), 64'(busy), 64'd0);
            chk($sformatf("abort_seq no_done e%0d", e), 64'(done), 64'd0);
            chk($sformatf("abort_seq result e%0d", e), 64'(result), 64'(last_result));
        end
        start = 1'b0; abort = 1'b0;
        $display("op abort_seq: aborted 5x5 at N+10, result=%h", result);

        // abort and start together in IDLE: not accepted
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle busy", 64'(busy), 64'd0);
        $display("op abort+start in IDLE: busy=%0d", busy);

        // reset mid-RUN clears everything
        @(negedge clk);
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            rst = (e == 20);
            @(posedge clk); #1;
        end
        chk("midrun_reset busy", 64'(busy), 64'd0);
        chk("midrun_reset done", 64'(done), 64'd0);
        chk("midrun_reset result", 64'(result), 64'd0);
        $display("op reset at N+20: busy=%0d done=%0d result=%h", busy, done, result);
        @(negedge clk);
        rst = 1'b0;
        last_result = 32'd0;

        // first start after reset accepted normally
        run_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 32'd25, "post_reset_5x5");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rh  = 1'($urandom);
            rsa = 1'($urandom);
            rsb = 1'($urandom);
            run_op(ra, rb, rh, rsa, rsb, ref_mul(ra, rb, rh, rsa, rsb), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
